uart_boot_ctrl: RTL and testbench

//  Sequences UART firmware upgrade in the SoC. When sw_uart_upgrade_b is low at

---
 rtl/uart_boot_ctrl_if.sv | 25 ++
 rtl/uart_boot_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_ctrl_if.sv
// Bundles the UART receive/transmit handshakes and the instruction-RAM write
// port seen by the boot controller.
interface uart_boot_ctrl_if #(
  parameter int AW = 12
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_busy;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;

  // The boot controller drives the transmit request and the RAM write port.
  modport master (
    input  rx_valid, rx_data, tx_busy,
    output tx_valid, tx_data, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  tx_valid, tx_data, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/uart_boot_ctrl.sv
// UART firmware-upgrade sequencer: streams an image into instruction RAM as
// little-endian words, answers ACK/NAK and holds the CPU in reset until done.
module uart_boot_ctrl #(
  parameter int unsigned RAM_SIZE = 16'h4000,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    sw_uart_upgrade_b,
  uart_boot_ctrl_if.master        bus,
  output logic                    cpu_rstb,
  output logic                    load_busy,
  output logic                    load_err
);

  localparam int AW = (RAM_SIZE > 4) ? $clog2(RAM_SIZE / 4) : 1;
  localparam int CW = $clog2(RAM_SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(RAM_SIZE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACK,
    S_RUN,
    S_NAK,
    S_ERR
  } state_t;

  state_t          state, next_state;
  logic [1:0]      rst_sync;
  logic            rst_n_int;
  logic [CW-1:0]   byte_cnt;
  logic [TW-1:0]   to_cnt;
  logic [23:0]     word_q;
  logic            started;
  logic            accept;
  logic            send_tx;
  logic [7:0]      tx_byte;

  logic            tx_valid_q;
  logic [7:0]      tx_data_q;
  logic            ram_we_q;
  logic [AW-1:0]   ram_addr_q;
  logic [31:0]     ram_wdata_q;
  logic            cpu_rstb_q;
  logic            load_busy_q;
  logic            load_err_q;

  // Assert asynchronously, release on a clock edge so every flop leaves reset together.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign started = (byte_cnt != '0);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= S_IDLE;
    else            state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    send_tx    = 1'b0;
    tx_byte    = ACK_BYTE;
    case (state)
      S_IDLE: next_state = sw_uart_upgrade_b ? S_RUN : S_LOAD;
      S_LOAD: begin
        if (bus.rx_valid) begin
          accept = 1'b1;
          if (byte_cnt == LAST_BYTE) next_state = S_ACK;
        end else if (started && (to_cnt == TO_LAST)) begin
          next_state = S_NAK;
        end
      end
      S_ACK: begin
        if (!bus.tx_busy && !tx_valid_q) begin
          send_tx    = 1'b1;
          next_state = S_RUN;
        end
      end
      S_NAK: begin
        tx_byte = NAK_BYTE;
        if (!bus.tx_busy && !tx_valid_q) begin
          send_tx    = 1'b1;
          next_state = S_ERR;
        end
      end
      S_RUN, S_ERR: next_state = state;
      default:      next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      byte_cnt    <= '0;
      to_cnt      <= '0;
      word_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rstb_q  <= 1'b0;
      load_busy_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      ram_we_q   <= 1'b0;
      tx_valid_q <= send_tx;
      if (send_tx) tx_data_q <= tx_byte;

      if (accept) begin
        byte_cnt <= byte_cnt + CW'(1);
        to_cnt   <= '0;
        case (byte_cnt[1:0])
          2'd0: word_q[7:0]   <= bus.rx_data;
          2'd1: word_q[15:8]  <= bus.rx_data;
          2'd2: word_q[23:16] <= bus.rx_data;
          2'd3: begin
            ram_we_q    <= 1'b1;
            ram_wdata_q <= {bus.rx_data, word_q};
            ram_addr_q  <= byte_cnt[AW+1:2];
          end
          default: ;
        endcase
      end else if ((state == S_LOAD) && started) begin
        to_cnt <= to_cnt + TW'(1);
      end

      // Status outputs track the state being entered so they line up with it.
      cpu_rstb_q  <= (next_state == S_RUN);
      load_busy_q <= (next_state == S_LOAD) || (next_state == S_ACK);
      load_err_q  <= (next_state == S_NAK)  || (next_state == S_ERR);
    end
  end

  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign cpu_rstb      = cpu_rstb_q;
  assign load_busy     = load_busy_q;
  assign load_err      = load_err_q;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Bench for uart_boot_ctrl: random images and gaps checked against a
// byte-stream model of the expected RAM writes and UART replies.
module tb_uart_boot_ctrl;

  localparam int RAM_SIZE = 16;
  localparam int TIMEOUT  = 100;
  localparam int AW       = 2;
  localparam int NWORDS   = RAM_SIZE / 4;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  logic sw   = 1'b1;
  logic cpu_rstb, load_busy, load_err;

  uart_boot_ctrl_if #(.AW(AW)) bus ();

  uart_boot_ctrl #(
    .RAM_SIZE (RAM_SIZE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rstb              (rstb),
    .sw_uart_upgrade_b (sw),
    .bus               (bus),
    .cpu_rstb          (cpu_rstb),
    .load_busy         (load_busy),
    .load_err          (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] img[$];
  logic       prev_txv = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  // Observed RAM writes and UART transmissions, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (bus.ram_we === 1'b1) wr_q.push_back('{bus.ram_addr, bus.ram_wdata});
    if (bus.tx_valid === 1'b1) begin
      tx_q.push_back(bus.tx_data);
      checks++;
      if (prev_txv === 1'b1) begin
        failures++;
        $display("FAIL tx_valid_back_to_back: got two consecutive cycles, required single-cycle pulses");
      end
    end
    prev_txv = bus.tx_valid;
  end

  // Little-endian word assembly straight from the byte stream.
  function automatic logic [31:0] model_word(input int w);
    return {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
  endfunction

  task automatic do_reset(input logic sw_val);
    @(negedge clk);
    rstb         = 1'b0;
    sw           = sw_val;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    wr_q.delete();
    tx_q.delete();
    rstb = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    repeat (idle) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_rstb, load_busy, load_err, bus.tx_valid, bus.ram_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {cpu_rstb, load_busy, load_err, bus.tx_valid, bus.ram_we});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_wdata, bus.tx_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h tx=%h, required zeros",
               bus.ram_addr, bus.ram_wdata, bus.tx_data);
    end
  endtask

  task automatic test_direct_boot();
    bit found;
    found = 1'b0;
    do_reset(1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (cpu_rstb === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL direct_boot_latency: cpu_rstb=%b, required 1 within 3 clk", cpu_rstb);
    end
    // Stray bytes and switch changes must not disturb RUN.
    @(negedge clk);
    sw = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), $urandom_range(2, 0));
    repeat (5) @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || tx_q.size() != 0) begin
      failures++;
      $display("FAIL direct_boot_quiet: got %0d writes %0d tx, required 0 and 0", wr_q.size(), tx_q.size());
    end
    checks++;
    if ({cpu_rstb, load_busy, load_err} !== 3'b100) begin
      failures++;
      $display("FAIL direct_boot_status: got %b, required 100", {cpu_rstb, load_busy, load_err});
    end
  endtask

  // One full image load; options cover sequential data, a maximal inter-byte
  // gap, a busy transmitter and extra bytes after completion.
  task automatic run_load(input string name, input bit seq, input int max_idle,
                          input int long_gap_at, input int busy_hold, input int extra);
    int waited;
    int idle;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    img.delete();
    for (int i = 0; i < RAM_SIZE; i++) img.push_back(seq ? 8'(i) : 8'($urandom));
    checks++;
    if ({cpu_rstb, load_busy, load_err} !== 3'b010) begin
      failures++;
      $display("FAIL %s_pre: got %b, required 010", name, {cpu_rstb, load_busy, load_err});
    end
    for (int i = 0; i < RAM_SIZE; i++) begin
      idle = (i == long_gap_at) ? TIMEOUT - 1 : $urandom_range(max_idle, 0);
      if (i == RAM_SIZE - 1 && busy_hold > 0) bus.tx_busy = 1'b1;
      send_byte(img[i], idle);
    end
    if (busy_hold > 0) begin
      repeat (busy_hold) @(negedge clk);
      checks++;
      if (tx_q.size() != 0 || cpu_rstb !== 1'b0 || load_busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy_hold: got tx=%0d cpu_rstb=%b busy=%b, required 0 0 1",
                 name, tx_q.size(), cpu_rstb, load_busy);
      end
      bus.tx_busy = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      sw = 1'($urandom);
      send_byte(8'($urandom), 0);
    end
    waited = 0;
    while (cpu_rstb !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != NWORDS) begin
      failures++;
      $display("FAIL %s_write_count: got %0d, required %0d", name, wr_q.size(), NWORDS);
    end
    for (int w = 0; w < NWORDS && w < wr_q.size(); w++) begin
      checks++;
      if (wr_q[w].addr !== AW'(w) || wr_q[w].data !== model_word(w)) begin
        failures++;
        $display("FAIL %s_word%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                 name, w, wr_q[w].addr, wr_q[w].data, w, model_word(w));
      end
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== ACK) begin
      failures++;
      $display("FAIL %s_ack: got %0d bytes first=%h, required one byte %h",
               name, tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, ACK);
    end
    checks++;
    if ({cpu_rstb, load_busy, load_err} !== 3'b100) begin
      failures++;
      $display("FAIL %s_done: got %b, required 100", name, {cpu_rstb, load_busy, load_err});
    end
  endtask

  task automatic test_sequential_load();
    run_load("seq_load", 1'b1, 0, -1, 0, 0);
  endtask

  task automatic test_random_load();
    for (int r = 0; r < 3; r++) run_load("rand_load", 1'b0, 4, -1, 0, 0);
  endtask

  task automatic test_timeout_boundary();
    run_load("gap_boundary", 1'b0, 2, 5, 0, 0);
  endtask

  task automatic test_tx_busy();
    run_load("tx_busy", 1'b0, 1, -1, 50, 0);
  endtask

  task automatic test_back_to_back();
    run_load("extra_bytes", 1'b0, 0, -1, 0, 5);
  endtask

  task automatic test_timeout();
    int err_k;
    int tx_k;
    err_k = -1;
    tx_k  = -1;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    img.delete();
    for (int i = 0; i < RAM_SIZE; i++) img.push_back(8'($urandom));
    // Before the first byte the loader waits indefinitely.
    repeat (3 * TIMEOUT) @(negedge clk);
    checks++;
    if ({load_busy, load_err} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_before_first: got busy/err=%b, required 10", {load_busy, load_err});
    end
    for (int i = 0; i < 5; i++) send_byte(img[i], $urandom_range(3, 0));
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      @(posedge clk);
      #1;
      if (load_err === 1'b1 && err_k < 0) err_k = k;
      if (bus.tx_valid === 1'b1 && tx_k < 0) tx_k = k;
    end
    checks++;
    if (err_k != TIMEOUT || tx_k != TIMEOUT + 1) begin
      failures++;
      $display("FAIL timeout_latency: got err@%0d tx@%0d, required err@%0d tx@%0d",
               err_k, tx_k, TIMEOUT, TIMEOUT + 1);
    end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    repeat (20) @(negedge clk);
    checks++;
    if (wr_q.size() != 1 || wr_q[0].addr !== '0 || wr_q[0].data !== model_word(0)) begin
      failures++;
      $display("FAIL timeout_writes: got %0d writes first=%h, required 1 write %h",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0].data : 32'hx, model_word(0));
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== NAK) begin
      failures++;
      $display("FAIL timeout_nak: got %0d bytes first=%h, required one byte %h",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, NAK);
    end
    checks++;
    if ({cpu_rstb, load_busy, load_err} !== 3'b001) begin
      failures++;
      $display("FAIL timeout_status: got %b, required 001", {cpu_rstb, load_busy, load_err});
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    img.delete();
    for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) send_byte(img[i], $urandom_range(2, 0));
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != 1 || wr_q[0].data !== model_word(0)) begin
      failures++;
      $display("FAIL midreset_partial: got %0d writes, required 1 write %h", wr_q.size(), model_word(0));
    end
    rstb = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({cpu_rstb, load_busy, load_err, bus.ram_we, bus.tx_valid} !== 5'b0 ||
        bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got ctrl=%b addr=%0d wdata=%h, required all zero",
               {cpu_rstb, load_busy, load_err, bus.ram_we, bus.tx_valid}, bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if (wr_q.size() != 1) begin
      failures++;
      $display("FAIL midreset_no_write: got %0d writes, required 1", wr_q.size());
    end
    run_load("reload", 1'b0, 2, -1, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    #2 rstb = 1'b0;
    test_reset();
    test_direct_boot();
    test_sequential_load();
    test_random_load();
    test_timeout();
    test_timeout_boundary();
    test_tx_busy();
    test_reset_mid_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
